// File: rtl/pe_mem_banks_if.sv
// pe_mem_banks_if: controller, AXI and swap-handshake bundle for pe_mem_banks.
// master = controller/AXI side, slave = the memory subsystem.
interface pe_mem_banks_if #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int DW    = 32,
    parameter int PW    = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
);
    logic                        weight_rd_en;
    logic [AW-1:0]               weight_rd_addr;
    logic [ROWS-1:0][DW-1:0]     weight_rd_dout;
    logic [COLS-1:0]             iact_rd_en;
    logic [COLS-1:0][AW-1:0]     iact_rd_addr;
    logic [COLS-1:0][DW-1:0]     iact_rd_dout;
    logic [ROWS-1:0]             psum_wr_en;
    logic [ROWS-1:0][AW-1:0]     psum_wr_addr;
    logic [ROWS-1:0][PW-1:0]     psum_wr_din;
    logic [ROWS-1:0][DW/8-1:0]   axi_weight_we;
    logic [ROWS-1:0][AW-1:0]     axi_weight_addr;
    logic [ROWS-1:0][DW-1:0]     axi_weight_din;
    logic [ROWS-1:0][DW-1:0]     axi_weight_dout;
    logic [COLS-1:0][DW/8-1:0]   axi_iact_we;
    logic [COLS-1:0][AW-1:0]     axi_iact_addr;
    logic [COLS-1:0][DW-1:0]     axi_iact_din;
    logic [COLS-1:0][DW-1:0]     axi_iact_dout;
    logic [ROWS-1:0][AW-1:0]     axi_psum_addr;
    logic [ROWS-1:0][PW-1:0]     axi_psum_dout;
    logic                        swap_req;
    logic                        swap_ack;
    logic                        bank_sel;
    logic                        busy;

    modport master (
        output weight_rd_en, weight_rd_addr, iact_rd_en, iact_rd_addr,
               psum_wr_en, psum_wr_addr, psum_wr_din,
               axi_weight_we, axi_weight_addr, axi_weight_din,
               axi_iact_we, axi_iact_addr, axi_iact_din, axi_psum_addr, swap_req,
        input  weight_rd_dout, iact_rd_dout, axi_weight_dout, axi_iact_dout,
               axi_psum_dout, swap_ack, bank_sel, busy
    );

    modport slave (
        input  weight_rd_en, weight_rd_addr, iact_rd_en, iact_rd_addr,
               psum_wr_en, psum_wr_addr, psum_wr_din,
               axi_weight_we, axi_weight_addr, axi_weight_din,
               axi_iact_we, axi_iact_addr, axi_iact_din, axi_psum_addr, swap_req,
        output weight_rd_dout, iact_rd_dout, axi_weight_dout, axi_iact_dout,
               axi_psum_dout, swap_ack, bank_sel, busy
    );
endinterface

// File: rtl/pe_mem_banks.sv
// pe_mem_banks: ping-pong weight/iact/psum banks; a swap engine exchanges halves and zero-fills the new active psum half.
// Optional macro PSUM_ACCUM_EN turns psum writes into a two-stage read-modify-write accumulate.
module pe_mem_banks #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int DW    = 32,
    parameter int PW    = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    pe_mem_banks_if.slave bus
);
    localparam int NB = DW / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, ACK} state_t;

    state_t        state, state_next;
    logic [AW-1:0] clr_cnt, clr_cnt_next;
    logic          bank_sel, toggle, clear_we, busy;

    logic [DW-1:0] weight_mem [ROWS][2*DEPTH];
    logic [DW-1:0] iact_mem   [COLS][2*DEPTH];
    logic [PW-1:0] psum_mem   [ROWS][2*DEPTH];

    logic [ROWS-1:0][DW-1:0] weight_rd_q, axi_weight_q;
    logic [COLS-1:0][DW-1:0] iact_rd_q, axi_iact_q;
    logic [ROWS-1:0][PW-1:0] axi_psum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            bank_sel <= 1'b0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            if (toggle) bank_sel <= ~bank_sel;
        end
    end

    // bank_sel flips on the accepting edge, so the clear already walks the new active half.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        toggle       = 1'b0;
        clear_we     = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt_next = '0;
                if (bus.swap_req) begin
                    toggle     = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clear_we     = 1'b1;
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) state_next = ACK;
            end
            ACK: begin
                if (!bus.swap_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign bus.busy     = busy;
    assign bus.swap_ack = (state == ACK);
    assign bus.bank_sel = bank_sel;

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            for (int b = 0; b < NB; b++)
                if (bus.axi_weight_we[r][b])
                    weight_mem[r][{~bank_sel, bus.axi_weight_addr[r]}][8*b +: 8] <= bus.axi_weight_din[r][8*b +: 8];
        for (int c = 0; c < COLS; c++)
            for (int b = 0; b < NB; b++)
                if (bus.axi_iact_we[c][b])
                    iact_mem[c][{~bank_sel, bus.axi_iact_addr[c]}][8*b +: 8] <= bus.axi_iact_din[c][8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_rd_q  <= '0;
            axi_weight_q <= '0;
            iact_rd_q    <= '0;
            axi_iact_q   <= '0;
            axi_psum_q   <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (bus.weight_rd_en)
                    weight_rd_q[r] <= weight_mem[r][{bank_sel, bus.weight_rd_addr}];
                axi_weight_q[r] <= weight_mem[r][{~bank_sel, bus.axi_weight_addr[r]}];
                axi_psum_q[r]   <= psum_mem[r][{~bank_sel, bus.axi_psum_addr[r]}];
            end
            for (int c = 0; c < COLS; c++) begin
                if (bus.iact_rd_en[c])
                    iact_rd_q[c] <= iact_mem[c][{bank_sel, bus.iact_rd_addr[c]}];
                axi_iact_q[c] <= iact_mem[c][{~bank_sel, bus.axi_iact_addr[c]}];
            end
        end
    end

    assign bus.weight_rd_dout  = weight_rd_q;
    assign bus.axi_weight_dout = axi_weight_q;
    assign bus.iact_rd_dout    = iact_rd_q;
    assign bus.axi_iact_dout   = axi_iact_q;
    assign bus.axi_psum_dout   = axi_psum_q;

`ifdef PSUM_ACCUM_EN
    logic [ROWS-1:0]         s1_valid, s1_half, s2_valid, s2_half;
    logic [ROWS-1:0][AW-1:0] s1_addr, s2_addr;
    logic [ROWS-1:0][PW-1:0] s1_din, s1_rdata, s2_sum, acc_sum;

    // Stage 1 read a stale word if stage 2 wrote the same location on that edge; take the registered sum instead.
    always_comb begin
        acc_sum = '0;
        for (int r = 0; r < ROWS; r++)
            acc_sum[r] = ((s2_valid[r] && s2_half[r] == s1_half[r] && s2_addr[r] == s1_addr[r])
                          ? s2_sum[r] : s1_rdata[r]) + s1_din[r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= '0;
            s1_half  <= '0;
            s1_addr  <= '0;
            s1_din   <= '0;
            s1_rdata <= '0;
            s2_valid <= '0;
            s2_half  <= '0;
            s2_addr  <= '0;
            s2_sum   <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                s1_valid[r] <= bus.psum_wr_en[r] && !busy;
                s1_half[r]  <= bank_sel;
                s1_addr[r]  <= bus.psum_wr_addr[r];
                s1_din[r]   <= bus.psum_wr_din[r];
                s1_rdata[r] <= psum_mem[r][{bank_sel, bus.psum_wr_addr[r]}];
                s2_valid[r] <= s1_valid[r];
                s2_half[r]  <= s1_half[r];
                s2_addr[r]  <= s1_addr[r];
                s2_sum[r]   <= acc_sum[r];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (clear_we) psum_mem[r][{bank_sel, clr_cnt}] <= '0;
`ifdef PSUM_ACCUM_EN
            if (s1_valid[r]) psum_mem[r][{s1_half[r], s1_addr[r]}] <= acc_sum[r];
`else
            if (bus.psum_wr_en[r] && !busy)
                psum_mem[r][{bank_sel, bus.psum_wr_addr[r]}] <= bus.psum_wr_din[r];
`endif
        end
    end
endmodule

// File: tb/tb_pe_mem_banks.sv
// tb_pe_mem_banks: randomized traffic against a half-level model; expected responses queue up and a negedge monitor checks them.
`timescale 1ns/1ps
module tb_pe_mem_banks;
    localparam int ROWS = 3, COLS = 3, DW = 32, PW = 64, DEPTH = 16, AW = $clog2(DEPTH), NB = DW / 8;
    localparam int K_CTRL = 0, K_WRD = 1, K_IRD = 2, K_AW = 3, K_AI = 4, K_AP = 5;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_ACK = 2;

    typedef struct {int due; int kind; int idx; logic [63:0] val;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0, checks = 0, passed = 0;
    exp_t sb [$];
    string kname [6] = '{"ctrl{ack,busy,sel}", "weight_rd_dout", "iact_rd_dout", "axi_weight_dout", "axi_iact_dout", "axi_psum_dout"};

    logic [DW-1:0] w_ref [ROWS][2][DEPTH];
    logic [DW-1:0] i_ref [COLS][2][DEPTH];
    logic [PW-1:0] p_ref [ROWS][2][DEPTH];
    logic [DW-1:0] w_hold [ROWS];
    logic [DW-1:0] i_hold [COLS];
    bit ref_sel = 1'b0, model_valid = 1'b0;
    int phase = P_IDLE, clear_left = 0;

    pe_mem_banks_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .PW(PW), .DEPTH(DEPTH)) bus ();
    pe_mem_banks #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .PW(PW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [63:0] actual_of(int kind, int idx);
        case (kind)
            K_CTRL:  return {61'b0, bus.swap_ack, bus.busy, bus.bank_sel};
            K_WRD:   return 64'(bus.weight_rd_dout[idx]);
            K_IRD:   return 64'(bus.iact_rd_dout[idx]);
            K_AW:    return 64'(bus.axi_weight_dout[idx]);
            K_AI:    return 64'(bus.axi_iact_dout[idx]);
            default: return bus.axi_psum_dout[idx];
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_output($sformatf("%s[%0d]@%0d", kname[e.kind], e.idx, e.due), actual_of(e.kind, e.idx), e.val);
        end
    end

    task automatic push(int kind, int idx, logic [63:0] val);
        sb.push_back('{cyc + 1, kind, idx, val});
    endtask

    task automatic idle_inputs();
        bus.weight_rd_en  = 1'b0;
        bus.iact_rd_en    = '0;
        bus.psum_wr_en    = '0;
        bus.axi_weight_we = '0;
        bus.axi_iact_we   = '0;
    endtask

    task automatic rand_inputs();
        bus.weight_rd_en   = 1'($urandom_range(0, 1));
        bus.weight_rd_addr = AW'($urandom_range(0, DEPTH - 1));
        for (int r = 0; r < ROWS; r++) begin
            bus.psum_wr_en[r]      = 1'($urandom_range(0, 1));
            bus.psum_wr_addr[r]    = AW'($urandom_range(0, 3));
            bus.psum_wr_din[r]     = {$urandom, $urandom};
            bus.axi_weight_we[r]   = NB'($urandom);
            bus.axi_weight_addr[r] = AW'($urandom_range(0, DEPTH - 1));
            bus.axi_weight_din[r]  = $urandom;
            bus.axi_psum_addr[r]   = AW'($urandom_range(0, DEPTH - 1));
        end
        for (int c = 0; c < COLS; c++) begin
            bus.iact_rd_en[c]    = 1'($urandom_range(0, 1));
            bus.iact_rd_addr[c]  = AW'($urandom_range(0, DEPTH - 1));
            bus.axi_iact_we[c]   = NB'($urandom);
            bus.axi_iact_addr[c] = AW'($urandom_range(0, DEPTH - 1));
            bus.axi_iact_din[c]  = $urandom;
        end
    endtask

    // Predict this edge's responses from the model, apply the edge's writes to it, then clock.
    task automatic apply_stimulus();
        logic [DW-1:0] nw;
        bit accept = (phase == P_IDLE);
        for (int r = 0; r < ROWS; r++) begin
            if (bus.weight_rd_en) w_hold[r] = w_ref[r][ref_sel][bus.weight_rd_addr];
            push(K_WRD, r, 64'(w_hold[r]));
            if (model_valid) begin
                push(K_AW, r, 64'(w_ref[r][!ref_sel][bus.axi_weight_addr[r]]));
                push(K_AP, r, p_ref[r][!ref_sel][bus.axi_psum_addr[r]]);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (bus.iact_rd_en[c]) i_hold[c] = i_ref[c][ref_sel][bus.iact_rd_addr[c]];
            push(K_IRD, c, 64'(i_hold[c]));
            if (model_valid) push(K_AI, c, 64'(i_ref[c][!ref_sel][bus.axi_iact_addr[c]]));
        end
        for (int r = 0; r < ROWS; r++) begin
            nw = w_ref[r][!ref_sel][bus.axi_weight_addr[r]];
            for (int b = 0; b < NB; b++)
                if (bus.axi_weight_we[r][b]) nw[8*b +: 8] = bus.axi_weight_din[r][8*b +: 8];
            w_ref[r][!ref_sel][bus.axi_weight_addr[r]] = nw;
            if (accept && bus.psum_wr_en[r])
`ifdef PSUM_ACCUM_EN
                p_ref[r][ref_sel][bus.psum_wr_addr[r]] = p_ref[r][ref_sel][bus.psum_wr_addr[r]] + bus.psum_wr_din[r];
`else
                p_ref[r][ref_sel][bus.psum_wr_addr[r]] = bus.psum_wr_din[r];
`endif
        end
        for (int c = 0; c < COLS; c++) begin
            nw = i_ref[c][!ref_sel][bus.axi_iact_addr[c]];
            for (int b = 0; b < NB; b++)
                if (bus.axi_iact_we[c][b]) nw[8*b +: 8] = bus.axi_iact_din[c][8*b +: 8];
            i_ref[c][!ref_sel][bus.axi_iact_addr[c]] = nw;
        end
        case (phase)
            P_IDLE: if (bus.swap_req) begin
                ref_sel = !ref_sel;
                for (int r = 0; r < ROWS; r++)
                    for (int a = 0; a < DEPTH; a++) p_ref[r][ref_sel][a] = '0;
                phase      = P_CLEAR;
                clear_left = DEPTH;
            end
            P_CLEAR: begin
                clear_left--;
                if (clear_left == 0) phase = P_ACK;
            end
            default: if (!bus.swap_req) phase = P_IDLE;
        endcase
        push(K_CTRL, 0, {61'b0, phase == P_ACK, phase != P_IDLE, ref_sel});
        @(posedge clk);
        #1;
    endtask

    task automatic do_swap(bit traffic, int extra_hold);
        idle_inputs();
        bus.swap_req = 1'b1;
        apply_stimulus();
        for (int k = 0; k < DEPTH + extra_hold; k++) begin
            if (traffic) rand_inputs(); else idle_inputs();
            apply_stimulus();
        end
        idle_inputs();
        bus.swap_req = 1'b0;
        apply_stimulus();
    endtask

    task automatic fill_shadow();
        for (int a = 0; a < DEPTH; a++) begin
            idle_inputs();
            for (int r = 0; r < ROWS; r++) begin
                bus.axi_weight_we[r] = '1; bus.axi_weight_addr[r] = AW'(a); bus.axi_weight_din[r] = $urandom;
            end
            for (int c = 0; c < COLS; c++) begin
                bus.axi_iact_we[c] = '1; bus.axi_iact_addr[c] = AW'(a); bus.axi_iact_din[c] = $urandom;
            end
            apply_stimulus();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        bus.swap_req = 1'b0;
        bus.weight_rd_addr = '0; bus.iact_rd_addr = '0; bus.psum_wr_addr = '0; bus.psum_wr_din = '0;
        bus.axi_weight_addr = '0; bus.axi_weight_din = '0; bus.axi_iact_addr = '0; bus.axi_iact_din = '0;
        bus.axi_psum_addr = '0;
        for (int r = 0; r < ROWS; r++) w_hold[r] = '0;
        for (int c = 0; c < COLS; c++) i_hold[c] = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset bank_sel", 64'(bus.bank_sel), 64'd0);
        check_output("reset busy", 64'(bus.busy), 64'd0);
        check_output("reset swap_ack", 64'(bus.swap_ack), 64'd0);
        check_output("reset weight_rd_dout", 64'(bus.weight_rd_dout), 64'd0);
        check_output("reset axi_psum_dout[0]", bus.axi_psum_dout[0], 64'd0);
        rst = 1'b0;

        fill_shadow();
        do_swap(1'b0, 0);
        fill_shadow();
        do_swap(1'b0, 0);
        model_valid = 1'b1;

        idle_inputs();
        bus.axi_weight_we[0] = '1; bus.axi_weight_addr[0] = AW'(2); bus.axi_weight_din[0] = 32'h11223344;
        bus.axi_weight_we[1] = '1; bus.axi_weight_addr[1] = AW'(2); bus.axi_weight_din[1] = 32'h11223344;
        apply_stimulus();
        idle_inputs();
        bus.axi_weight_we[0] = 4'b0100; bus.axi_weight_din[0] = 32'hAABBCCDD;
        bus.axi_weight_we[1] = 4'b0101; bus.axi_weight_din[1] = 32'hAABBCCDD;
        apply_stimulus();
        check_output("axi weight read-first", 64'(bus.axi_weight_dout[0]), 64'h11223344);
        idle_inputs();
        apply_stimulus();
        check_output("axi weight we=0100", 64'(bus.axi_weight_dout[0]), 64'h11BB3344);
        check_output("axi weight we=0101", 64'(bus.axi_weight_dout[1]), 64'h11BB33DD);

        idle_inputs();
        bus.axi_iact_we[1] = '1; bus.axi_iact_addr[1] = AW'(5); bus.axi_iact_din[1] = 32'hDEADBEEF;
        apply_stimulus();
        do_swap(1'b0, 2);
        idle_inputs();
        bus.iact_rd_en[1] = 1'b1; bus.iact_rd_addr[1] = AW'(5);
        check_output("iact_rd_dout[1] before enable edge", 64'(bus.iact_rd_dout[1]), 64'd0);
        apply_stimulus();
        check_output("iact_rd_dout[1] deadbeef", 64'(bus.iact_rd_dout[1]), 64'hDEADBEEF);

        idle_inputs();
        bus.psum_wr_en = 3'b101;
        bus.psum_wr_addr[0] = AW'(3); bus.psum_wr_din[0] = 64'd7;
        bus.psum_wr_addr[2] = AW'(9); bus.psum_wr_din[2] = 64'd5;
        apply_stimulus();
        idle_inputs();
        bus.psum_wr_en = 3'b110;
        bus.psum_wr_addr[1] = AW'(4); bus.psum_wr_din[1] = '1;
        bus.psum_wr_din[2] = 64'd6;
        apply_stimulus();
        idle_inputs();
        bus.psum_wr_en = 3'b110;
        bus.psum_wr_din[1] = 64'd1;
        bus.psum_wr_din[2] = 64'd7;
        apply_stimulus();
        idle_inputs();
        apply_stimulus();
        do_swap(1'b0, 0);
        idle_inputs();
        bus.axi_psum_addr[0] = AW'(3); bus.axi_psum_addr[1] = AW'(4); bus.axi_psum_addr[2] = AW'(9);
        apply_stimulus();
        check_output("psum row0 addr3", bus.axi_psum_dout[0], 64'd7);
`ifdef PSUM_ACCUM_EN
        check_output("psum row1 wrap", bus.axi_psum_dout[1], 64'd0);
        check_output("psum row2 accum", bus.axi_psum_dout[2], 64'd18);
`else
        check_output("psum row1 overwrite", bus.axi_psum_dout[1], 64'd1);
        check_output("psum row2 overwrite", bus.axi_psum_dout[2], 64'd7);
`endif
        bus.axi_psum_addr[0] = AW'(8);
        apply_stimulus();
        check_output("psum row0 cleared addr8", bus.axi_psum_dout[0], 64'd0);

        for (int round = 0; round < 6; round++) begin
            for (int n = 0; n < 40; n++) begin
                rand_inputs();
                apply_stimulus();
            end
            do_swap(round[0], round);
        end

        idle_inputs();
        bus.swap_req = 1'b1;
        apply_stimulus();
        idle_inputs();
        apply_stimulus();
        apply_stimulus();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_output("mid-clear reset bank_sel", 64'(bus.bank_sel), 64'd0);
        check_output("mid-clear reset busy", 64'(bus.busy), 64'd0);
        check_output("mid-clear reset swap_ack", 64'(bus.swap_ack), 64'd0);
        check_output("mid-clear reset iact_rd_dout", 64'(bus.iact_rd_dout), 64'd0);
        bus.swap_req = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
